// File: rtl/gcd_pkg.sv
// Definitions shared by the GCD feeder and its datapath: default operand width,
// job counter width and the sequencer FSM encoding.
package gcd_pkg;
  localparam int GCD_WIDTH   = 16;
  localparam int JOB_COUNT_W = 8;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_CHECK  = 3'd1,
    ST_LOAD_A = 3'd2,
    ST_LOAD_B = 3'd3,
    ST_WAIT   = 3'd4
  } gcd_state_e;
endpackage

// File: rtl/gcd_pair_fifo.sv
// Synchronous FIFO of {a,b} operand pairs. Pointers carry an extra wrap bit so
// full and empty are distinguishable without a separate occupancy counter.
module gcd_pair_fifo #(
  parameter int DW    = 32,
  parameter int DEPTH = 2
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  logic          pop,
  input  logic [DW-1:0] wdata,
  output logic [DW-1:0] head,
  output logic          full,
  output logic          empty
);
  localparam int AW = $clog2(DEPTH);

  logic [DW-1:0] mem [DEPTH];
  logic [AW:0]   wr_ptr;
  logic [AW:0]   rd_ptr;
  logic          do_push;
  logic          do_pop;

  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  // Storage is flop-based, so the head is a registered value read in place.
  assign head    = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + (AW+1)'(1);
      if (do_pop)  rd_ptr <= rd_ptr + (AW+1)'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= wdata;
  end
endmodule

// File: rtl/gcd_operand_sequencer.sv
// Buffers operand pairs and replays them onto the GCD stage's serial start/data
// protocol, dropping zero operands and aborting jobs that never report done.
module gcd_operand_sequencer
  import gcd_pkg::*;
#(
  parameter int WIDTH      = GCD_WIDTH,
  parameter int FIFO_DEPTH = 2,
  parameter int TIMEOUT    = 1024
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [WIDTH-1:0]       in_a,
  input  logic [WIDTH-1:0]       in_b,
  output logic [WIDTH-1:0]       gcd_data,
  output logic                   gcd_start,
  input  logic                   gcd_done,
  output logic                   busy,
  output logic                   zero_err,
  output logic                   timeout,
  output logic [JOB_COUNT_W-1:0] job_count
);
  localparam int WD_W = $clog2(TIMEOUT);
  localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT - 1);

  gcd_state_e         state;
  logic [WIDTH-1:0]   a_q;
  logic [WIDTH-1:0]   b_q;
  logic [WD_W-1:0]    wd_cnt;
  logic [2*WIDTH-1:0] head;
  logic               fifo_full;
  logic               fifo_empty;
  logic               push;
  logic               pop;

  assign in_ready = !fifo_full && !rst;
  assign push     = in_valid && in_ready;
  assign pop      = (state == ST_IDLE) && !fifo_empty;

  gcd_pair_fifo #(
    .DW    (2*WIDTH),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .pop   (pop),
    .wdata ({in_a, in_b}),
    .head  (head),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  // Outputs are registered from the transition taken, so they line up with
  // the state they belong to.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_IDLE;
      a_q       <= '0;
      b_q       <= '0;
      wd_cnt    <= '0;
      gcd_data  <= '0;
      gcd_start <= 1'b0;
      busy      <= 1'b0;
      zero_err  <= 1'b0;
      timeout   <= 1'b0;
      job_count <= '0;
    end else begin
      gcd_data  <= '0;
      gcd_start <= 1'b0;
      zero_err  <= 1'b0;
      timeout   <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (!fifo_empty) begin
            a_q   <= head[2*WIDTH-1:WIDTH];
            b_q   <= head[WIDTH-1:0];
            state <= ST_CHECK;
            busy  <= 1'b1;
          end
        end
        ST_CHECK: begin
          // A zero operand would never converge in the subtractive GCD.
          if (a_q == '0 || b_q == '0) begin
            zero_err <= 1'b1;
            state    <= ST_IDLE;
            busy     <= 1'b0;
          end else begin
            gcd_start <= 1'b1;
            gcd_data  <= a_q;
            state     <= ST_LOAD_A;
          end
        end
        ST_LOAD_A: begin
          gcd_data <= b_q;
          state    <= ST_LOAD_B;
        end
        ST_LOAD_B: begin
          wd_cnt <= '0;
          state  <= ST_WAIT;
        end
        ST_WAIT: begin
          // Completion takes priority over a watchdog expiry in the same cycle.
          if (gcd_done) begin
            job_count <= job_count + 1'b1;
            state     <= ST_IDLE;
            busy      <= 1'b0;
          end else if (wd_cnt == WD_LAST) begin
            timeout <= 1'b1;
            state   <= ST_IDLE;
            busy    <= 1'b0;
          end else begin
            wd_cnt <= wd_cnt + 1'b1;
          end
        end
        default: begin
          state <= ST_IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end
endmodule
